// File: rtl/mem_arbiter.sv
// Burst-granular arbiter sharing the main-memory port between the I-cache and D-cache fill FSMs.
// Optional ARB_RR_EN: simultaneous requests in IDLE go to the requester that did not own last.
module mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_grant,
    output logic        i_data_valid,
    input  logic        d_req,
    input  logic        d_wrt,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_grant,
    output logic        d_data_valid,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_data_valid,
    output logic        proto_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;
    localparam logic [CNT_W-1:0] OUTS_MAX = {CNT_W{1'b1}};

    if (2 ** CNT_W <= MEM_LAT) begin : g_cnt_w_too_narrow
        // A counter this narrow would saturate while reads are still legally in flight.
        localparam int CfgBad = 1;
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] outs_q, outs_d;
    logic             last_q, last_d;
    logic             flight_q, flight_d;
    logic             proto_err_q, proto_err_d;
    logic             rd_issue;
    logic             rd_return;
    logic             spurious;
    logic             tie_to_i;

`ifdef ARB_RR_EN
    assign tie_to_i = (last_q == OWNER_D);
`else
    assign tie_to_i = 1'b0;
`endif

    // flight_q names the owner whose reads are in flight; last_q only moves once they drain.
    always_comb begin
        state_d  = state_q;
        flight_d = flight_q;
        last_d   = last_q;
        case (state_q)
            IDLE: begin
                if ((d_req || d_wrt) && !(i_req && tie_to_i)) begin
                    state_d  = OWN_D;
                    flight_d = OWNER_D;
                end else if (i_req) begin
                    state_d  = OWN_I;
                    flight_d = OWNER_I;
                end
            end
            OWN_I: begin
                if (!i_req) state_d = DRAIN;
            end
            OWN_D: begin
                if (!d_req && !d_wrt) state_d = DRAIN;
            end
            DRAIN: begin
                if (outs_q == '0) begin
                    state_d = IDLE;
                    last_d  = flight_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            OWN_I: begin
                mem_enable = i_req;
                mem_addr   = i_addr;
            end
            OWN_D: begin
                mem_enable = d_req | d_wrt;
                mem_wr     = d_wrt;
                mem_addr   = d_addr;
                mem_wdata  = d_wdata;
            end
            default: ;
        endcase
    end

    // A return with nothing outstanding is dropped and flagged, never counted.
    always_comb begin
        rd_issue    = mem_enable & ~mem_wr;
        rd_return   = mem_data_valid & (outs_q != '0);
        spurious    = mem_data_valid & (outs_q == '0);
        outs_d      = outs_q;
        proto_err_d = proto_err_q | spurious;
        if (rd_issue && !rd_return && (outs_q != OUTS_MAX)) begin
            outs_d = outs_q + 1'b1;
        end else if (!rd_issue && rd_return) begin
            outs_d = outs_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            outs_q      <= '0;
            last_q      <= OWNER_I;
            flight_q    <= OWNER_I;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            outs_q      <= outs_d;
            last_q      <= last_d;
            flight_q    <= flight_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign i_grant      = (state_q == OWN_I);
    assign d_grant      = (state_q == OWN_D);
    assign i_data_valid = rd_return & (flight_q == OWNER_I);
    assign d_data_valid = rd_return & (flight_q == OWNER_D);
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: bursts, write-through, arbitration ties, spurious returns, reset.
// Build with ARB_RR_EN defined to exercise round-robin tie expectations.
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;
    localparam int CNT_W   = 3;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OWN_I = 2'd1;
    localparam logic [1:0] S_OWN_D = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;
`ifdef ARB_RR_EN
    localparam bit TIE_A_D = 1'b0;
`else
    localparam bit TIE_A_D = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_grant;
    logic        i_data_valid;
    logic        d_req;
    logic        d_wrt;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_grant;
    logic        d_data_valid;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_data_valid;
    logic        proto_err;
    logic        spur;

    int total = 0;
    int bad   = 0;
    int i_dv_cnt = 0;
    int d_dv_cnt = 0;

    logic [MEM_LAT-1:0] pipe = '0;
    logic [37:0]        all_out;

    mem_arbiter #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_grant        (i_grant),
        .i_data_valid   (i_data_valid),
        .d_req          (d_req),
        .d_wrt          (d_wrt),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_grant        (d_grant),
        .d_data_valid   (d_data_valid),
        .mem_enable     (mem_enable),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_data_valid (mem_data_valid),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    // Memory model: every read issue returns exactly MEM_LAT cycles later.
    always @(posedge clk) pipe <= {pipe[MEM_LAT-2:0], mem_enable & ~mem_wr};
    assign mem_data_valid = pipe[MEM_LAT-1] | spur;

    assign all_out = {i_grant, d_grant, i_data_valid, d_data_valid,
                      mem_enable, mem_wr, mem_addr, mem_wdata};

    always @(negedge clk) begin
        if (i_data_valid) i_dv_cnt++;
        if (d_data_valid) d_dv_cnt++;
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic run_burst(input bit is_d, input int beats, input logic [15:0] base);
        int idv0, ddv0, n;
        idv0 = i_dv_cnt;
        ddv0 = d_dv_cnt;
        nxt();
        if (is_d) d_req = 1'b1; else i_req = 1'b1;
        i_addr = base;
        d_addr = base;
        settle();
        chk("burst_idle_grant", {i_grant, d_grant, mem_enable}, 3'b000);
        for (int k = 0; k < beats; k++) begin
            nxt();
            i_addr = 16'(base + 16'(k));
            d_addr = 16'(base + 16'(k));
            settle();
            chk("burst_grant", {i_grant, d_grant}, is_d ? 2'b01 : 2'b10);
            chk("burst_issue", {mem_enable, mem_wr, mem_addr}, {2'b10, 16'(base + 16'(k))});
            chk("burst_outs", dut.outs_q, (k < MEM_LAT) ? k : MEM_LAT);
        end
        nxt();
        i_req = 1'b0;
        d_req = 1'b0;
        settle();
        chk("burst_stop", mem_enable, 1'b0);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            nxt();
            settle();
            if (dut.state_q == S_DRAIN) begin
                n++;
                chk("drain_no_grant", {i_grant, d_grant, mem_enable}, 3'b000);
            end else begin
                break;
            end
        end
        chk("burst_back_idle", dut.state_q, S_IDLE);
        chk("burst_drain_len", n, MEM_LAT);
        chk("burst_i_dv", i_dv_cnt - idv0, is_d ? 0 : beats);
        chk("burst_d_dv", d_dv_cnt - ddv0, is_d ? beats : 0);
        chk("burst_last", dut.last_q, is_d);
    endtask

    task automatic run_tie(input bit exp_d, input int beats);
        int last_dv, gnt_cyc, wdv0;
        bit got;
        last_dv = -100;
        gnt_cyc = 0;
        got = 1'b0;
        wdv0 = exp_d ? d_dv_cnt : i_dv_cnt;
        nxt();
        i_req = 1'b1;
        d_req = 1'b1;
        i_addr = 16'h2000;
        d_addr = 16'h4000;
        settle();
        chk("tie_idle", {i_grant, d_grant}, 2'b00);
        for (int k = 0; k < beats; k++) begin
            nxt();
            settle();
            chk("tie_winner", {i_grant, d_grant}, exp_d ? 2'b01 : 2'b10);
        end
        nxt();
        if (exp_d) d_req = 1'b0; else i_req = 1'b0;
        settle();
        for (int c = 0; c < 40; c++) begin
            nxt();
            settle();
            if (exp_d ? d_data_valid : i_data_valid) last_dv = c;
            if (exp_d ? i_grant : d_grant) begin
                got = 1'b1;
                gnt_cyc = c;
                break;
            end
        end
        chk("tie_loser_granted", got, 1'b1);
        chk("tie_gap", gnt_cyc - last_dv, 3);
        chk("tie_winner_dv", (exp_d ? d_dv_cnt : i_dv_cnt) - wdv0, beats);
        i_req = 1'b0;
        d_req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            nxt();
            settle();
            if (dut.state_q == S_IDLE) break;
        end
        chk("tie_back_idle", dut.state_q, S_IDLE);
        chk("tie_last", dut.last_q, !exp_d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int idv0, ddv0;
        rst = 1'b1;
        i_req = 1'b0;
        i_addr = '0;
        d_req = 1'b0;
        d_wrt = 1'b0;
        d_addr = '0;
        d_wdata = '0;
        spur = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        chk("rst_outputs", all_out, 38'h0);
        chk("rst_state", dut.state_q, S_IDLE);
        chk("rst_outs", dut.outs_q, 0);
        chk("rst_last", dut.last_q, 1'b0);
        chk("rst_proto_err", proto_err, 1'b0);

        // I-only 8-beat burst at 0x1230..0x1237.
        run_burst(1'b0, 8, 16'h1230);

        // D write-through, then a cycle with read and write both requested.
        nxt();
        d_wrt = 1'b1;
        d_addr = 16'h00F0;
        d_wdata = 16'hBEEF;
        settle();
        chk("wr_idle_no_access", {d_grant, mem_enable}, 2'b00);
        nxt();
        settle();
        chk("wr_issue", {d_grant, mem_enable, mem_wr, mem_addr, mem_wdata}, {3'b111, 16'h00F0, 16'hBEEF});
        nxt();
        d_req = 1'b1;
        d_addr = 16'h00F1;
        d_wdata = 16'h1111;
        settle();
        chk("wr_beats_rd", {mem_enable, mem_wr, mem_addr, mem_wdata}, {2'b11, 16'h00F1, 16'h1111});
        nxt();
        d_req = 1'b0;
        d_wrt = 1'b0;
        settle();
        chk("wr_released", {d_grant, mem_enable}, 2'b10);
        nxt();
        settle();
        chk("wr_drain", dut.state_q, S_DRAIN);
        chk("wr_outs_zero", dut.outs_q, 0);
        nxt();
        settle();
        chk("wr_drain_one_cycle", dut.state_q, S_IDLE);
        chk("wr_last_d", dut.last_q, 1'b1);

        // Tie with last=D, a short I burst to make last=I, then tie again.
        run_tie(TIE_A_D, 2);
        run_burst(1'b0, 2, 16'h5000);
        run_tie(1'b1, 2);

        // Spurious return in IDLE.
        idv0 = i_dv_cnt;
        ddv0 = d_dv_cnt;
        nxt();
        spur = 1'b1;
        settle();
        chk("spur_no_dv", {i_data_valid, d_data_valid, proto_err}, 3'b000);
        nxt();
        spur = 1'b0;
        settle();
        chk("spur_proto_err", proto_err, 1'b1);
        nxt();
        settle();
        chk("spur_sticky", proto_err, 1'b1);
        chk("spur_dv_count", {i_dv_cnt - idv0, d_dv_cnt - ddv0}, 0);

        // Reset during OWN_I with three reads outstanding.
        nxt();
        i_req = 1'b1;
        i_addr = 16'h3000;
        settle();
        for (int k = 0; k < 3; k++) begin
            nxt();
            i_addr = 16'(16'h3000 + 16'(k));
            settle();
        end
        nxt();
        settle();
        chk("mid_state", dut.state_q, S_OWN_I);
        chk("mid_outs", dut.outs_q, 3);
        rst = 1'b1;
        idv0 = i_dv_cnt;
        ddv0 = d_dv_cnt;
        nxt();
        rst = 1'b0;
        i_req = 1'b0;
        settle();
        chk("mid_rst_state", dut.state_q, S_IDLE);
        chk("mid_rst_outs", dut.outs_q, 0);
        chk("mid_rst_outputs", all_out, 38'h0);
        chk("mid_rst_proto_err", proto_err, 1'b0);
        nxt();
        settle();
        chk("late_ret_proto_err", proto_err, 1'b1);
        repeat (4) nxt();
        settle();
        chk("late_ret_dropped", {i_dv_cnt - idv0, d_dv_cnt - ddv0}, 0);
        chk("late_ret_idle", dut.state_q, S_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
